board_debouncer: RTL and testbench

- Filters raw 32-square board snapshots from the sensor shift-register scanner before they reach the memory-mapped board registers.
- Sits between the sensor scanner and the memory manager.
- Commits a snapshot only after it repeats for STABLE_SCANS consecutive scans.
- On each commit it reports which squares were lifted or placed, holds that event until the CPU acknowledges it, and flags a stalled scanner.

---
 rtl/board_debouncer.sv | 214 +++++++++++++++++++++
 tb/tb_board_debouncer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_debouncer.sv
// board_debouncer
//
// Purpose: filters raw board snapshots from the sensor scanner. A snapshot is
// committed to stable_board only after STABLE_SCANS consecutive identical
// scans. Each committed change is reported as lifted/placed masks that are
// held until the CPU acknowledges them. A watchdog flags a stalled scanner.
//
// Ports:
//   clock          - system clock, rising edge
//   reset          - asynchronous, active-high reset
//   raw_board      - scanner snapshot (1 = piece present)
//   raw_valid      - one-cycle pulse qualifying raw_board
//   ack            - one-cycle pulse consuming the pending event
//   stable_board   - last committed board
//   lifted         - squares that went 1->0 since the last ack
//   placed         - squares that went 0->1 since the last ack
//   change_pending - an event is held in lifted/placed
//   overflow       - more than one commit was merged into the pending event
//   sensor_fault   - no raw_valid for TIMEOUT_CYCLES cycles or more
//   primed         - first stable snapshot has been committed
module board_debouncer #(
  parameter int WIDTH          = 32,
  parameter int STABLE_SCANS   = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_board,
  input  logic             raw_valid,
  input  logic             ack,
  output logic [WIDTH-1:0] stable_board,
  output logic [WIDTH-1:0] lifted,
  output logic [WIDTH-1:0] placed,
  output logic             change_pending,
  output logic             overflow,
  output logic             sensor_fault,
  output logic             primed
);

  localparam int CNT_W = $clog2(STABLE_SCANS + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SCANS);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_UNPRIMED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_PENDING  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] candidate_q, candidate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] lifted_q, lifted_d;
  logic [WIDTH-1:0] placed_q, placed_d;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             fault_q, fault_d;
  logic             primed_q, primed_d;

  logic             match_s;
  logic             commit_s;
  logic             differ_s;
  logic [WIDTH-1:0] lift_s;
  logic [WIDTH-1:0] place_s;

  // Scan filter: track the candidate snapshot and its saturating repeat count.
  always_comb begin
    candidate_d = candidate_q;
    cnt_d       = cnt_q;
    commit_s    = 1'b0;
    match_s     = (raw_board == candidate_q);
    if (raw_valid) begin
      if (match_s) begin
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        candidate_d = raw_board;
        cnt_d       = CNT_W'(1);
      end
      // A mismatching scan restarts the count, so with a single-scan filter
      // the count stays saturated yet still represents a fresh commit.
      commit_s = (cnt_d == CNT_MAX) && ((cnt_q < CNT_MAX) || !match_s);
    end else begin
      commit_s = 1'b0;
    end
  end

  // Commit / event state machine; masks are taken against the old stable board.
  always_comb begin
    state_d    = state_q;
    stable_d   = stable_q;
    lifted_d   = lifted_q;
    placed_d   = placed_q;
    overflow_d = overflow_q;
    differ_s   = (candidate_d != stable_q);
    lift_s     = stable_q & ~candidate_d;
    place_s    = ~stable_q & candidate_d;
    case (state_q)
      ST_UNPRIMED: begin
        if (commit_s) begin
          stable_d = candidate_d;
          state_d  = ST_TRACK;
        end else begin
          state_d  = ST_UNPRIMED;
        end
      end
      ST_TRACK: begin
        if (commit_s && differ_s) begin
          stable_d   = candidate_d;
          lifted_d   = lift_s;
          placed_d   = place_s;
          overflow_d = 1'b0;
          state_d    = ST_PENDING;
        end else begin
          state_d    = ST_TRACK;
        end
      end
      ST_PENDING: begin
        if (commit_s && differ_s) begin
          stable_d = candidate_d;
          if (ack) begin
            lifted_d   = lift_s;
            placed_d   = place_s;
            overflow_d = 1'b0;
          end else begin
            lifted_d   = lifted_q | lift_s;
            placed_d   = placed_q | place_s;
            overflow_d = 1'b1;
          end
          state_d = ST_PENDING;
        end else if (commit_s) begin
          // Commit of the already-stable board: nothing changes, ack included.
          state_d = ST_PENDING;
        end else if (ack) begin
          lifted_d   = '0;
          placed_d   = '0;
          overflow_d = 1'b0;
          state_d    = ST_TRACK;
        end else begin
          state_d = ST_PENDING;
        end
      end
      default: begin
        state_d    = ST_UNPRIMED;
        stable_d   = '0;
        lifted_d   = '0;
        placed_d   = '0;
        overflow_d = 1'b0;
      end
    endcase
    primed_d  = (state_d != ST_UNPRIMED);
    pending_d = (state_d == ST_PENDING);
  end

  // Watchdog: count idle cycles, saturate, and flag a stalled scanner.
  always_comb begin
    wd_d    = wd_q;
    fault_d = fault_q;
    if (raw_valid) begin
      wd_d    = '0;
      fault_d = 1'b0;
    end else if (wd_q < WD_MAX) begin
      wd_d    = wd_q + WD_W'(1);
      fault_d = (wd_d == WD_MAX) ? 1'b1 : fault_q;
    end else begin
      wd_d    = wd_q;
      fault_d = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_UNPRIMED;
      candidate_q <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      stable_q    <= '0;
      lifted_q    <= '0;
      placed_q    <= '0;
      pending_q   <= 1'b0;
      overflow_q  <= 1'b0;
      fault_q     <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      candidate_q <= candidate_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      stable_q    <= stable_d;
      lifted_q    <= lifted_d;
      placed_q    <= placed_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      fault_q     <= fault_d;
      primed_q    <= primed_d;
    end
  end

  assign stable_board   = stable_q;
  assign lifted         = lifted_q;
  assign placed         = placed_q;
  assign change_pending = pending_q;
  assign overflow       = overflow_q;
  assign sensor_fault   = fault_q;
  assign primed         = primed_q;

endmodule

// File: tb/tb_board_debouncer.sv
// tb_board_debouncer
//
// Purpose: directed scenarios plus randomized traffic for board_debouncer,
// compared every cycle against a scan-history reference model.
module tb_board_debouncer;

  localparam int W = 32;
  localparam int S = 3;
  localparam int T = 100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  raw_board = '0;
  logic          raw_valid = 1'b0;
  logic          ack = 1'b0;
  logic [W-1:0]  stable_board, lifted, placed;
  logic          change_pending, overflow, sensor_fault, primed;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_lifted, m_placed;
  bit           m_pend, m_ovf, m_primed;
  int           m_idle;

  logic [W-1:0] pool[4];

  board_debouncer #(.WIDTH(W), .STABLE_SCANS(S), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .raw_board(raw_board), .raw_valid(raw_valid),
    .ack(ack), .stable_board(stable_board), .lifted(lifted), .placed(placed),
    .change_pending(change_pending), .overflow(overflow),
    .sensor_fault(sensor_fault), .primed(primed)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_stable = '0; m_lifted = '0; m_placed = '0;
    m_pend = 1'b0; m_ovf = 1'b0; m_primed = 1'b0; m_idle = 0;
  endtask

  // One clock edge of the reference: commit when the trailing run of
  // identical scans has just reached S.
  task automatic model_edge(input bit rv, input logic [W-1:0] rb, input bit ak);
    int run;
    bit commit;
    logic [W-1:0] l, p;
    commit = 1'b0;
    if (rv) begin
      hist.push_back(rb);
      if (hist.size() > S + 1) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] == rb) run++;
        else break;
      end
      commit = (run == S);
      m_idle = 0;
    end else if (m_idle < T) begin
      m_idle++;
    end
    if (commit) begin
      if (!m_primed) begin
        m_stable = rb;
        m_primed = 1'b1;
      end else if (rb != m_stable) begin
        l = m_stable & ~rb;
        p = ~m_stable & rb;
        if (!m_pend || ak) begin
          m_lifted = l; m_placed = p; m_ovf = 1'b0;
        end else begin
          m_lifted = m_lifted | l; m_placed = m_placed | p; m_ovf = 1'b1;
        end
        m_pend = 1'b1;
        m_stable = rb;
      end
    end else if (ak) begin
      m_pend = 1'b0; m_ovf = 1'b0; m_lifted = '0; m_placed = '0;
    end
  endtask

  task automatic compare_all();
    check_eq("stable_board", stable_board, m_stable);
    check_eq("lifted", lifted, m_lifted);
    check_eq("placed", placed, m_placed);
    check_eq("change_pending", {31'd0, change_pending}, {31'd0, m_pend});
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check_eq("sensor_fault", {31'd0, sensor_fault}, {31'd0, (m_idle >= T)});
    check_eq("primed", {31'd0, primed}, {31'd0, m_primed});
  endtask

  task automatic step(input bit rv, input logic [W-1:0] rb, input bit ak);
    raw_valid = rv; raw_board = rb; ack = ak;
    @(posedge clock);
    model_edge(rv, rb, ak);
    #1;
    compare_all();
    raw_valid = 1'b0; ack = 1'b0;
  endtask

  task automatic scan(input logic [W-1:0] v);
    step(1'b1, v, 1'b0);
    repeat (9) step(1'b0, 32'h0000_0000, 1'b0);
  endtask

  // Asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #3 reset = 1'b1;
    #1;
    check_eq("rst_stable", stable_board, 32'h0000_0000);
    check_eq("rst_lifted", lifted, 32'h0000_0000);
    check_eq("rst_placed", placed, 32'h0000_0000);
    check_eq("rst_pending", {31'd0, change_pending}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    check_eq("rst_fault", {31'd0, sensor_fault}, 32'd0);
    check_eq("rst_primed", {31'd0, primed}, 32'd0);
    model_reset();
    #2 reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    #2 reset = 1'b0;

    // Prime
    scan(32'h0000_0FFF);
    scan(32'h0000_0FFF);
    check_eq("prime2_stable", stable_board, 32'h0000_0000);
    check_eq("prime2_primed", {31'd0, primed}, 32'd0);
    scan(32'h0000_0FFF);
    check_eq("prime3_stable", stable_board, 32'h0000_0FFF);
    check_eq("prime3_primed", {31'd0, primed}, 32'd1);
    check_eq("prime3_pending", {31'd0, change_pending}, 32'd0);

    // Move
    scan(32'h0001_0FFE);
    scan(32'h0001_0FFE);
    step(1'b1, 32'h0001_0FFE, 1'b0);
    check_eq("move_pending", {31'd0, change_pending}, 32'd1);
    check_eq("move_lifted", lifted, 32'h0000_0001);
    check_eq("move_placed", placed, 32'h0001_0000);
    repeat (9) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    check_eq("ack_pending", {31'd0, change_pending}, 32'd0);
    check_eq("ack_lifted", lifted, 32'h0000_0000);
    check_eq("ack_placed", placed, 32'h0000_0000);

    // Bounce rejection
    for (int i = 0; i < 10; i++) scan(i[0] ? 32'h0000_0FFE : 32'h0000_0FFF);
    check_eq("bounce_stable", stable_board, 32'h0001_0FFE);
    check_eq("bounce_pending", {31'd0, change_pending}, 32'd0);

    // Overflow merge: get bit0 set, then lift bit0, then place bit16
    repeat (3) scan(32'h0000_0FFF);
    step(1'b0, 32'h0, 1'b1);
    repeat (3) scan(32'h0000_0FFE);
    repeat (3) scan(32'h0001_0FFE);
    check_eq("ovf_lifted", lifted, 32'h0000_0001);
    check_eq("ovf_placed", placed, 32'h0001_0000);
    check_eq("ovf_flag", {31'd0, overflow}, 32'd1);
    scan(32'h0001_0FFF);
    scan(32'h0001_0FFF);
    step(1'b1, 32'h0001_0FFF, 1'b1);
    check_eq("ackc_lifted", lifted, 32'h0000_0000);
    check_eq("ackc_placed", placed, 32'h0000_0001);
    check_eq("ackc_overflow", {31'd0, overflow}, 32'd0);
    check_eq("ackc_pending", {31'd0, change_pending}, 32'd1);
    step(1'b0, 32'h0, 1'b1);

    // Watchdog
    scan(32'h0F0F_0F0F);
    step(1'b1, 32'h0F0F_0F0F, 1'b0);
    repeat (99) step(1'b0, 32'h0, 1'b0);
    check_eq("wd_99", {31'd0, sensor_fault}, 32'd0);
    step(1'b0, 32'h0, 1'b0);
    check_eq("wd_100", {31'd0, sensor_fault}, 32'd1);
    repeat (5) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0F0F_0F0F, 1'b0);
    check_eq("wd_clear", {31'd0, sensor_fault}, 32'd0);
    check_eq("wd_kept_state", stable_board, 32'h0F0F_0F0F);

    // Reset mid-filter
    scan(32'h1234_5678);
    scan(32'h1234_5678);
    async_reset();
    repeat (3) scan(32'h00FF_00FF);
    check_eq("reprime_stable", stable_board, 32'h00FF_00FF);
    check_eq("reprime_primed", {31'd0, primed}, 32'd1);
    check_eq("reprime_pending", {31'd0, change_pending}, 32'd0);

    // Randomized traffic
    pool[0] = 32'h0000_0FFF;
    pool[1] = 32'h0001_0FFE;
    pool[2] = $urandom();
    pool[3] = 32'hFFFF_0000;
    for (int n = 0; n < 4000; n++) begin
      logic [W-1:0] v;
      v = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 15) == 0) v = v ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 299) == 0) begin
        repeat (T + 10) step(1'b0, 32'h0, 1'b0);
      end
      step($urandom_range(0, 3) == 0, v, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
